// File: rtl/imm_gen_pipe.sv
// Registered immediate generator for the decode stage, valid/ready with a 2-entry skid buffer.
// Optional CSR immediate decode (zimm / CSR address) is enabled by defining IMM_GEN_ZICSR_EN.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;

    // Every format places its sign at bit 31 of a 32-bit image, so one signed cast extends to XLEN.
    function automatic logic [XLEN+2:0] decode(input logic [31:0] inst);
        logic [31:0]     imm32_s;
        logic [XLEN-1:0] immx_s;
        logic [2:0]      fmt_s;
        imm32_s = 32'd0;
        fmt_s   = FMT_NONE;
        case (inst[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: begin
                fmt_s   = FMT_I;
                imm32_s = {{20{inst[31]}}, inst[31:20]};
            end
            7'b0011011: begin
                if (XLEN == 64) begin
                    fmt_s   = FMT_I;
                    imm32_s = {{20{inst[31]}}, inst[31:20]};
                end else begin
                    fmt_s   = FMT_NONE;
                    imm32_s = 32'd0;
                end
            end
            7'b0100011: begin
                fmt_s   = FMT_S;
                imm32_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            7'b1100011: begin
                fmt_s   = FMT_B;
                imm32_s = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                fmt_s   = FMT_U;
                imm32_s = {inst[31:12], 12'd0};
            end
            7'b1101111: begin
                fmt_s   = FMT_J;
                imm32_s = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
`ifdef IMM_GEN_ZICSR_EN
            7'b1110011: begin
                if (inst[14]) begin
                    fmt_s   = FMT_Z;
                    imm32_s = {27'd0, inst[19:15]};
                end else begin
                    fmt_s   = FMT_I;
                    imm32_s = {{20{inst[31]}}, inst[31:20]};
                end
            end
`endif
            default: begin
                fmt_s   = FMT_NONE;
                imm32_s = 32'd0;
            end
        endcase
        immx_s = XLEN'($signed(imm32_s));
        return {fmt_s, immx_s};
    endfunction

    logic             out_valid_r, skid_valid_r;
    logic [XLEN-1:0]  out_imm_r, skid_imm_r;
    logic [2:0]       out_fmt_r, skid_fmt_r;
    logic [TAG_W-1:0] out_tag_r, skid_tag_r;

    logic [XLEN-1:0]  dec_imm_s;
    logic [2:0]       dec_fmt_s;
    logic             accept_s, out_free_s, move_s, load_out_s, load_skid_s;
    logic             out_valid_nxt_s, skid_valid_nxt_s;

    // Decode the offered instruction word.
    always_comb begin
        {dec_fmt_s, dec_imm_s} = decode(in_inst);
    end

    // Handshake control; the skid only fills while the output register is full and stalled.
    always_comb begin
        accept_s         = in_valid && !skid_valid_r;
        out_free_s       = !out_valid_r || out_ready;
        move_s           = out_free_s && skid_valid_r && !flush;
        load_out_s       = out_free_s && accept_s && !flush;
        load_skid_s      = !out_free_s && accept_s && !flush;
        out_valid_nxt_s  = out_valid_r;
        skid_valid_nxt_s = skid_valid_r;
        if (flush) begin
            out_valid_nxt_s  = 1'b0;
            skid_valid_nxt_s = 1'b0;
        end else if (out_free_s) begin
            out_valid_nxt_s  = skid_valid_r || accept_s;
            skid_valid_nxt_s = 1'b0;
        end else begin
            out_valid_nxt_s  = 1'b1;
            skid_valid_nxt_s = skid_valid_r || accept_s;
        end
    end

    // Valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
        end else begin
            out_valid_r  <= out_valid_nxt_s;
            skid_valid_r <= skid_valid_nxt_s;
        end
    end

    // Data registers load only on accept or on a skid-to-output move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_imm_r  <= '0;
            out_fmt_r  <= 3'd0;
            out_tag_r  <= '0;
            skid_imm_r <= '0;
            skid_fmt_r <= 3'd0;
            skid_tag_r <= '0;
        end else begin
            if (move_s) begin
                out_imm_r <= skid_imm_r;
                out_fmt_r <= skid_fmt_r;
                out_tag_r <= skid_tag_r;
            end else if (load_out_s) begin
                out_imm_r <= dec_imm_s;
                out_fmt_r <= dec_fmt_s;
                out_tag_r <= in_tag;
            end else begin
                out_imm_r <= out_imm_r;
                out_fmt_r <= out_fmt_r;
                out_tag_r <= out_tag_r;
            end
            if (load_skid_s) begin
                skid_imm_r <= dec_imm_s;
                skid_fmt_r <= dec_fmt_s;
                skid_tag_r <= in_tag;
            end else begin
                skid_imm_r <= skid_imm_r;
                skid_fmt_r <= skid_fmt_r;
                skid_tag_r <= skid_tag_r;
            end
        end
    end

    assign in_ready  = !skid_valid_r;
    assign out_valid = out_valid_r;
    assign out_imm   = out_imm_r;
    assign out_fmt   = out_fmt_r;
    assign out_tag   = out_tag_r;

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

- Registered, parametrised immediate generator for the decode stage. Generalises the combinational immediate decoder to XLEN=32/64 and adds a format-code output and a sideband tag.
- A valid/ready handshake with a 2-entry skid buffer (output register plus skid register) gives 1-cycle latency and full throughput under backpressure.
- Sits between fetch/instruction buffer and the register-read stage.

## Interface
Parameters:
- XLEN, 32, immediate output width; legal values 32 or 64.
- TAG_W, 32, width of opaque sideband (typically PC) carried alongside the instruction.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- flush  input  1  synchronous kill of all buffered entries.
- in_valid  input  1  instruction presented.
- in_ready  output  1  block can accept this cycle.
- in_inst  input  32  instruction word.
- in_tag  input  TAG_W  sideband, passed through unchanged.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_imm  output  XLEN  sign/zero-extended immediate.
- out_fmt  output  3  format: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm).
- out_tag  output  TAG_W  sideband of the result.

## Operation
Decode is on opcode inst[6:0]. Sign bit is inst[31], extended to XLEN.

Opcode decode:
- I: 0000011, 0010011, 1100111; also 0011011 only when XLEN=64.
  - imm = sext(inst[31:20]).
  - Shift-immediate forms use the same raw field; the consumer masks shamt.
- S: 0100011.
  - imm = sext({inst[31:25], inst[11:7]}).
- B: 1100011.
  - imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
- U: 0110111, 0010111.
  - imm = sext({inst[31:12], 12'b0}); upper bits are ones on XLEN=64 when inst[31]=1.
- J: 1101111.
  - imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
- Any other opcode: out_fmt=0, out_imm=0. This is not an error.

Buffering:
- in_ready = !skid_valid (registered state only; no combinational path from out_ready).
- Accept when in_valid && in_ready. The decoded entry goes:
  - to the output register if it is empty or being drained this cycle (out_ready=1);
  - otherwise to the skid register.
- When out_valid && out_ready && skid_valid: the skid entry moves to the output register and the skid is cleared. A simultaneous new accept is impossible because in_ready=0.
- Order is strictly preserved; no entry is duplicated or dropped except by flush.
- flush=1: at the next edge out_valid=0 and skid_valid=0; an input offered in the same cycle is discarded. flush has priority over accept and drain.

## Timing
- Latency: accepted at edge N, visible on out_* after edge N (same cycle as N+1 sampling).
- Throughput: 1 per cycle while out_ready=1.
- Backpressure: at most 2 entries are held; in_ready falls the cycle after the second entry is stored. in_ready rises the cycle after the skid drains.
- out_* are stable while out_valid && !out_ready.
- Reset values: out_valid=0, out_imm=0, out_fmt=0, out_tag=0, skid empty, hence in_ready=1.
- Reset asserted mid-transfer drops all entries immediately (asynchronous).
- Data registers update only on accept or move. Valid bits use reset; data registers are reset to 0 as well.

## Configuration
- IMM_GEN_ZICSR_EN defined:
  - opcode 1110011 with inst[14]=1 gives out_fmt=6 and out_imm = zero-extended inst[19:15];
  - opcode 1110011 with inst[14]=0 gives out_fmt=1 and the I immediate (CSR address field).
- Undefined: opcode 1110011 gives out_fmt=0, out_imm=0. No other behaviour changes.

## Test plan
- Reset release, XLEN=32: in_ready=1, out_valid=0, out_imm=0.
- Back-to-back, out_ready=1, one per cycle:
  - 0xFFF00093 -> imm 0xFFFFFFFF, fmt 1;
  - 0x12345037 -> imm 0x12345000, fmt 4;
  - 0xFE000EE3 -> imm 0xFFFFFFFC, fmt 3;
  - 0xFF9FF06F -> imm 0xFFFFFFF8, fmt 5.
  - Each appears 1 cycle after acceptance, tags in order.
- XLEN=64: 0x80000037 -> imm 0xFFFFFFFF80000000, fmt 4; 0x0000001B (addiw) -> fmt 1.
- Backpressure: out_ready=0, offer tags 1, 2, 3 on consecutive cycles.
  - Tags 1 and 2 are accepted; in_ready=0 when tag 3 is offered, so tag 3 is held.
  - Raise out_ready: outputs appear 1, 2, 3 with no gaps after the first.
- With 2 entries held, assert flush together with in_valid: the next cycle out_valid=0 and in_ready=1, and no flushed tag ever appears.
- IMM_GEN_ZICSR_EN defined: 0x3008D073 (csrrwi) -> imm 0x00000011, fmt 6. Undefined: fmt 0, imm 0.
